centroid_divider: RTL and testbench

//  Downstream of the cluster PE. After an iteration's points are assigned, computes the new centre.

---
 rtl/centroid_divider.sv | 165 ++++++++++++++++
 tb/tb_centroid_divider.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_divider.sv
// -----------------------------------------------------------------------------
// centroid_divider
//   Computes a new cluster centre from the cluster PE's per-dimension
//   accumulators and its point counter: center[d] = floor(acc[d] / count),
//   saturated to the coordinate range. All dimensions are divided in parallel
//   by a restoring divider that resolves one quotient bit per clock. The new
//   centre is also compared with the centre used in this iteration so the
//   controller can detect convergence.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active low
//   start       in   request, only sampled while idle
//   acc_in      in   DIM accumulators, dim d at [d*ACC_SIZE +: ACC_SIZE]
//   count_in    in   points in the cluster (divisor)
//   old_center  in   centre used this iteration, dim d at [d*DIM_SIZE +: DIM_SIZE]
//   busy        out  operation in progress
//   done        out  one-cycle pulse, results valid from this cycle
//   center_out  out  new centre, held until the next done
//   converged   out  center_out equals the captured old centre
//   empty       out  count was zero, center_out is the old centre
// -----------------------------------------------------------------------------
module centroid_divider #(
  parameter  int DIM         = 3,
  parameter  int DATA_RANGE  = 255,
  parameter  int MAX_N       = 1000,
  localparam int DIM_SIZE    = $clog2(DATA_RANGE),
  localparam int CNT_SIZE    = $clog2(MAX_N),
  localparam int ACC_SIZE    = DIM_SIZE + CNT_SIZE,
  localparam int CENTER_SIZE = DIM * DIM_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIM*ACC_SIZE-1:0] acc_in,
  input  logic [CNT_SIZE-1:0]     count_in,
  input  logic [CENTER_SIZE-1:0]  old_center,
  output logic                    busy,
  output logic                    done,
  output logic [CENTER_SIZE-1:0]  center_out,
  output logic                    converged,
  output logic                    empty
);

  localparam int REM_SIZE = CNT_SIZE + 1;
  localparam int IDX_W    = $clog2(ACC_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FINISH
  } state_t;

  state_t                    r_state;
  logic [DIM*ACC_SIZE-1:0]   r_acc;
  logic [CNT_SIZE-1:0]       r_count;
  logic [CENTER_SIZE-1:0]    r_old;
  logic [DIM*ACC_SIZE-1:0]   r_quot;
  logic [DIM*REM_SIZE-1:0]   r_rem;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_busy;
  logic                      r_done;
  logic [CENTER_SIZE-1:0]    r_center;
  logic                      r_converged;
  logic                      r_empty;

  logic [DIM*ACC_SIZE-1:0]   w_quot_next;
  logic [DIM*REM_SIZE-1:0]   w_rem_next;
  logic [CENTER_SIZE-1:0]    w_center_new;

  // One restoring-division step per dimension, plus saturation of the
  // finished quotient into the coordinate range.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_dim
      logic [ACC_SIZE-1:0] w_acc_d;
      logic [ACC_SIZE-1:0] w_quot_d;
      logic [REM_SIZE-1:0] w_shift;
      logic                w_ge;

      assign w_acc_d  = r_acc[gi*ACC_SIZE +: ACC_SIZE];
      assign w_quot_d = r_quot[gi*ACC_SIZE +: ACC_SIZE];
      // The remainder is always below count, so its top bit is zero before
      // the shift and can be dropped.
      assign w_shift  = {r_rem[gi*REM_SIZE +: CNT_SIZE], w_acc_d[r_idx]};
      assign w_ge     = (w_shift >= {1'b0, r_count});

      assign w_rem_next[gi*REM_SIZE +: REM_SIZE] =
        w_ge ? (w_shift - {1'b0, r_count}) : w_shift;
      // Dividend bits are consumed MSB first, so quotient bits shift in at the LSB.
      assign w_quot_next[gi*ACC_SIZE +: ACC_SIZE] = {w_quot_d[ACC_SIZE-2:0], w_ge};

      assign w_center_new[gi*DIM_SIZE +: DIM_SIZE] =
        (|w_quot_d[ACC_SIZE-1:DIM_SIZE]) ? {DIM_SIZE{1'b1}} : w_quot_d[DIM_SIZE-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_old       <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_center    <= '0;
      r_converged <= 1'b0;
      r_empty     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc   <= acc_in;
            r_count <= count_in;
            r_old   <= old_center;
            r_quot  <= '0;
            r_rem   <= '0;
            r_idx   <= IDX_W'(ACC_SIZE - 1);
            r_busy  <= 1'b1;
            // A zero divisor skips the division entirely.
            r_state <= (count_in != '0) ? S_DIV : S_FINISH;
          end
        end
        S_DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          if (r_idx == '0) begin
            r_state <= S_FINISH;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_count == '0) begin
            r_center    <= r_old;
            r_converged <= 1'b1;
            r_empty     <= 1'b1;
          end else begin
            r_center    <= w_center_new;
            r_converged <= (w_center_new == r_old);
            r_empty     <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign center_out = r_center;
  assign converged  = r_converged;
  assign empty      = r_empty;

endmodule

// File: tb/tb_centroid_divider.sv
// -----------------------------------------------------------------------------
// tb_centroid_divider
//   Directed scenarios and randomized operations for centroid_divider, checked
//   against a plain-arithmetic reference (integer divide, clamp, compare).
// -----------------------------------------------------------------------------
module tb_centroid_divider;

  localparam int DS = 8;
  localparam int CS = 10;
  localparam int AS = 18;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [3*AS-1:0] acc_in;
  logic [CS-1:0]  count_in;
  logic [3*DS-1:0] old_center;
  logic           busy;
  logic           done;
  logic [3*DS-1:0] center_out;
  logic           converged;
  logic           empty;

  int n_cmp = 0;
  int n_err = 0;

  centroid_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .acc_in     (acc_in),
    .count_in   (count_in),
    .old_center (old_center),
    .busy       (busy),
    .done       (done),
    .center_out (center_out),
    .converged  (converged),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3*AS-1:0] pack_acc(input int a0, input int a1, input int a2);
    return {AS'(a2), AS'(a1), AS'(a0)};
  endfunction

  function automatic logic [3*DS-1:0] pack_ctr(input int c0, input int c1, input int c2);
    return {DS'(c2), DS'(c1), DS'(c0)};
  endfunction

  // Reference: floor divide, clamp to 255, empty cluster keeps old centre.
  function automatic void model(input logic [3*AS-1:0] a, input logic [CS-1:0] n,
                                input logic [3*DS-1:0] o, output logic [3*DS-1:0] c,
                                output logic conv, output logic emp);
    int unsigned q;
    if (n == 0) begin
      c = o; conv = 1'b1; emp = 1'b1;
    end else begin
      c = '0;
      for (int d = 0; d < 3; d++) begin
        q = int'(a[d*AS +: AS]) / int'(n);
        if (q > 255) q = 255;
        c[d*DS +: DS] = q[7:0];
      end
      conv = (c == o);
      emp  = 1'b0;
    end
  endfunction

  function automatic int exp_latency(input logic [CS-1:0] n);
    return (n == 0) ? 2 : AS + 2;
  endfunction

  // Issues one request, scrambles inputs after acceptance, and waits for done.
  // edges counts clock edges from the accepting edge (inclusive) to done.
  task automatic run_op(input logic [3*AS-1:0] a, input logic [CS-1:0] n,
                        input logic [3*DS-1:0] o, output int edges,
                        output logic busy_first, output logic overlap);
    @(negedge clk);
    acc_in = a; count_in = n; old_center = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_in = 54'({$urandom(), $urandom()});
    count_in = 10'($urandom());
    old_center = 24'($urandom());
    edges = 1;
    busy_first = busy;
    overlap = 1'b0;
    while (done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1;
    acc_in = pack_acc(1000, 2000, 3000); count_in = 10; old_center = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (center_out !== 24'h0) begin n_err++; $display("FAIL reset_center: got %h want 0", center_out); end
    n_cmp++; if (converged !== 1'b0 || empty !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got conv=%b empty=%b want 0/0", converged, empty);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    $display("test_reset: outputs cleared");
  endtask

  task automatic test_basic();
    int e; logic bf, ov;
    run_op(pack_acc(1000, 2000, 2540), 10, pack_ctr(0, 0, 0), e, bf, ov);
    n_cmp++; if (e !== 20) begin n_err++; $display("FAIL basic_latency: got %0d edges want 20", e); end
    n_cmp++; if (center_out !== pack_ctr(100, 200, 254)) begin
      n_err++; $display("FAIL basic_center: got %h want %h", center_out, pack_ctr(100, 200, 254));
    end
    n_cmp++; if (converged !== 1'b0 || empty !== 1'b0) begin
      n_err++; $display("FAIL basic_flags: got conv=%b empty=%b want 0/0", converged, empty);
    end
    n_cmp++; if (bf !== 1'b1 || busy !== 1'b0 || ov !== 1'b0) begin
      n_err++; $display("FAIL basic_busy: got first=%b at_done=%b overlap=%b want 1/0/0", bf, busy, ov);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    $display("test_basic: center=%h latency=%0d", center_out, e);
  endtask

  task automatic test_floor_saturate();
    int e; logic bf, ov;
    run_op(pack_acc(7, 0, 5000), 2, pack_ctr(3, 0, 0), e, bf, ov);
    n_cmp++; if (e !== 20) begin n_err++; $display("FAIL sat_latency: got %0d edges want 20", e); end
    n_cmp++; if (center_out !== pack_ctr(3, 0, 255)) begin
      n_err++; $display("FAIL sat_center: got %h want %h", center_out, pack_ctr(3, 0, 255));
    end
    n_cmp++; if (converged !== 1'b0 || empty !== 1'b0) begin
      n_err++; $display("FAIL sat_flags: got conv=%b empty=%b want 0/0", converged, empty);
    end
    $display("test_floor_saturate: center=%h", center_out);
  endtask

  task automatic test_empty();
    int e; logic bf, ov;
    run_op(pack_acc(500, 600, 700), 0, pack_ctr(12, 34, 56), e, bf, ov);
    n_cmp++; if (e !== 2) begin n_err++; $display("FAIL empty_latency: got %0d edges want 2", e); end
    n_cmp++; if (center_out !== pack_ctr(12, 34, 56)) begin
      n_err++; $display("FAIL empty_center: got %h want %h", center_out, pack_ctr(12, 34, 56));
    end
    n_cmp++; if (converged !== 1'b1 || empty !== 1'b1) begin
      n_err++; $display("FAIL empty_flags: got conv=%b empty=%b want 1/1", converged, empty);
    end
    n_cmp++; if (bf !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL empty_busy: got first=%b at_done=%b want 1/0", bf, busy);
    end
    $display("test_empty: center=%h", center_out);
  endtask

  task automatic test_convergence();
    int e; logic bf, ov;
    run_op(pack_acc(120, 240, 360), 3, pack_ctr(40, 80, 120), e, bf, ov);
    n_cmp++; if (center_out !== pack_ctr(40, 80, 120)) begin
      n_err++; $display("FAIL conv_center: got %h want %h", center_out, pack_ctr(40, 80, 120));
    end
    n_cmp++; if (converged !== 1'b1 || empty !== 1'b0) begin
      n_err++; $display("FAIL conv_flags: got conv=%b empty=%b want 1/0", converged, empty);
    end
    // Flags and centre must hold after the done pulse.
    repeat (3) @(negedge clk);
    n_cmp++; if (center_out !== pack_ctr(40, 80, 120) || converged !== 1'b1) begin
      n_err++; $display("FAIL conv_hold: got %h conv=%b want %h conv=1", center_out, converged, pack_ctr(40, 80, 120));
    end
    $display("test_convergence: center=%h converged=%b", center_out, converged);
  endtask

  task automatic test_busy_ignore();
    int edges, n_done, first_e;
    logic [3*DS-1:0] first_c;
    @(negedge clk);
    acc_in = pack_acc(900, 450, 90); count_in = 9; old_center = pack_ctr(1, 2, 3); start = 1'b1;
    @(negedge clk);
    start = 1'b0; edges = 1; n_done = 0; first_e = 0; first_c = '0;
    while (edges < 60) begin
      if (edges == 5) begin
        acc_in = pack_acc(2000, 2000, 2000); count_in = 8; old_center = '0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin first_e = edges; first_c = center_out; end
      end
    end
    start = 1'b0;
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL busy_ignore_count: got %0d dones want 1", n_done); end
    n_cmp++; if (first_e !== 20) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 20", first_e); end
    n_cmp++; if (first_c !== pack_ctr(100, 50, 10)) begin
      n_err++; $display("FAIL busy_ignore_center: got %h want %h", first_c, pack_ctr(100, 50, 10));
    end
    $display("test_busy_ignore: dones=%0d center=%h", n_done, first_c);
  endtask

  task automatic test_reset_mid();
    int edges, n_done, e;
    logic bf, ov, x_conv, x_emp;
    logic [3*DS-1:0] x_c;
    @(negedge clk);
    acc_in = pack_acc(3000, 1500, 600); count_in = 6; old_center = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; edges = 1;
    while (edges < 9) begin @(negedge clk); edges++; end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0/0", busy, done);
    end
    n_cmp++; if (center_out !== 24'h0 || converged !== 1'b0 || empty !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: got %h conv=%b empty=%b want 0/0/0", center_out, converged, empty);
    end
    n_done = 0;
    repeat (30) begin @(negedge clk); if (done === 1'b1) n_done++; end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d dones want 0", n_done); end
    run_op(pack_acc(777, 1554, 2331), 7, pack_ctr(111, 222, 0), e, bf, ov);
    model(pack_acc(777, 1554, 2331), 7, pack_ctr(111, 222, 0), x_c, x_conv, x_emp);
    n_cmp++; if (e !== 20 || center_out !== x_c || converged !== x_conv || empty !== x_emp) begin
      n_err++; $display("FAIL midrst_recover: got e=%0d %h %b %b want 20 %h %b %b",
                        e, center_out, converged, empty, x_c, x_conv, x_emp);
    end
    $display("test_reset_mid: recovered center=%h", center_out);
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    logic x_conv, x_emp;
    logic [3*DS-1:0] x_c;
    @(negedge clk);
    acc_in = pack_acc(640, 1280, 64); count_in = 64; old_center = pack_ctr(10, 20, 1); start = 1'b1;
    e1 = 0;
    do begin @(negedge clk); e1++; end while (done !== 1'b1 && e1 < 100);
    n_cmp++; if (e1 !== 20 || center_out !== pack_ctr(10, 20, 1) || converged !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: got e=%0d %h conv=%b want 20 %h 1", e1, center_out, converged, pack_ctr(10, 20, 1));
    end
    acc_in = pack_acc(0, 100000, 255); count_in = 1; old_center = '0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_pulse: got done=%b busy=%b want 0/1", done, busy);
    end
    e2 = 1;
    while (done !== 1'b1 && e2 < 100) begin @(negedge clk); e2++; end
    start = 1'b0;
    model(pack_acc(0, 100000, 255), 1, '0, x_c, x_conv, x_emp);
    n_cmp++; if (e2 !== 20 || center_out !== x_c || converged !== x_conv) begin
      n_err++; $display("FAIL b2b_second: got e=%0d %h conv=%b want 20 %h %b", e2, center_out, converged, x_c, x_conv);
    end
    $display("test_back_to_back: latencies %0d/%0d center=%h", e1, e2, center_out);
  endtask

  task automatic test_random();
    int e; logic bf, ov, x_conv, x_emp;
    logic [3*AS-1:0] a; logic [CS-1:0] n; logic [3*DS-1:0] o, x_c;
    int sel;
    for (int it = 0; it < 24; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      n = '0;
      else if (sel <= 3) n = 10'($urandom_range(1, 4));
      else               n = 10'($urandom_range(1, 1023));
      a = pack_acc(int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                   int'($urandom_range(0, 262143)));
      o = 24'($urandom());
      model(a, n, o, x_c, x_conv, x_emp);
      if ($urandom_range(0, 2) == 0) begin
        o = x_c;
        model(a, n, o, x_c, x_conv, x_emp);
      end
      run_op(a, n, o, e, bf, ov);
      n_cmp++; if (e !== exp_latency(n) || bf !== 1'b1 || ov !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_timing: got e=%0d busy_first=%b overlap=%b want %0d/1/0",
                          it, e, bf, ov, exp_latency(n));
      end
      n_cmp++; if (center_out !== x_c) begin
        n_err++; $display("FAIL rand%0d_center: got %h want %h (n=%0d)", it, center_out, x_c, n);
      end
      n_cmp++; if (converged !== x_conv || empty !== x_emp) begin
        n_err++; $display("FAIL rand%0d_flags: got conv=%b empty=%b want %b/%b", it, converged, empty, x_conv, x_emp);
      end
      $display("test_random[%0d]: n=%0d center=%h conv=%b empty=%b", it, n, center_out, converged, empty);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; acc_in = '0; count_in = '0; old_center = '0;
    test_reset();
    test_basic();
    test_floor_saturate();
    test_empty();
    test_convergence();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
